// File: rtl/instruction_fetch_controller_pkg.sv
// Shared FSM encodings and PC step for the instruction fetch controller.
// Latency: n/a (constants only). Backpressure: n/a.
package instruction_fetch_controller_pkg;

    localparam logic [2:0] IFC_IDLE  = 3'd0;
    localparam logic [2:0] IFC_FETCH = 3'd1;
    localparam logic [2:0] IFC_HOLD  = 3'd2;
    localparam logic [2:0] IFC_DROP  = 3'd3;
    localparam logic [2:0] IFC_LOAD  = 3'd4;
    localparam logic [2:0] IFC_HALT  = 3'd5;

    localparam logic [31:0] IFC_PC_STEP = 32'd4;

    function automatic logic ifc_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_controller.sv
// Fetches one word at a time (single outstanding read), presents it to decode; IFC_BOOT_LOADER_EN adds a program-load write path.
// Latency: request registered one edge after IDLE decision; instruction valid the edge after imem_rvalid.
// Backpressure: holds if_pc/if_instr and issues no request while if_valid && !if_ready.
module instruction_fetch_controller
    import instruction_fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        load_req,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ack,
    output logic        fault
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        fault_q, fault_d;
    logic        halt_pend_q, halt_pend_d;
    logic        redir_ok, redir_bad;

`ifdef IFC_BOOT_LOADER_EN
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        load_ack_q, load_ack_d;
`endif

    assign redir_ok  = redirect_valid &&  ifc_aligned(redirect_pc[1:0]);
    assign redir_bad = redirect_valid && !ifc_aligned(redirect_pc[1:0]);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        fault_d     = fault_q;
        halt_pend_d = halt_pend_q;
`ifdef IFC_BOOT_LOADER_EN
        imem_we_d    = 1'b0;
        imem_wdata_d = imem_wdata_q;
        load_ack_d   = 1'b0;
`endif
        case (state_q)
            IFC_IDLE: begin
                if (redir_bad) begin
                    fault_d = 1'b1;
                    state_d = IFC_HALT;
                end else if (redir_ok) begin
                    pc_d = redirect_pc;
`ifdef IFC_BOOT_LOADER_EN
                end else if (load_req) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = load_addr;
                    imem_wdata_d = load_data;
                    load_ack_d   = 1'b1;
                    state_d      = IFC_LOAD;
`endif
                end else begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    state_d     = IFC_FETCH;
                end
            end
            // A redirect coinciding with the returning word means nothing is left in flight.
            IFC_FETCH: begin
                if (redir_bad) begin
                    fault_d     = 1'b1;
                    halt_pend_d = !imem_rvalid;
                    state_d     = imem_rvalid ? IFC_HALT : IFC_DROP;
                end else if (redir_ok) begin
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid ? IFC_IDLE : IFC_DROP;
                end else if (imem_rvalid) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc_q;
                    pc_d       = pc_q + IFC_PC_STEP;
                    if_valid_d = 1'b1;
                    state_d    = IFC_HOLD;
                end
            end
            IFC_HOLD: begin
                if (redir_bad) begin
                    fault_d    = 1'b1;
                    if_valid_d = 1'b0;
                    state_d    = IFC_HALT;
                end else if (redir_ok) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    state_d    = IFC_IDLE;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = IFC_IDLE;
                end
            end
            IFC_DROP: begin
                if (!halt_pend_q) begin
                    if (redir_bad) begin
                        fault_d     = 1'b1;
                        halt_pend_d = 1'b1;
                    end else if (redir_ok) begin
                        pc_d = redirect_pc;
                    end
                end
                if (imem_rvalid) begin
                    state_d = halt_pend_d ? IFC_HALT : IFC_IDLE;
                end
            end
            IFC_LOAD: begin
                state_d = IFC_IDLE;
                if (redir_bad) begin
                    fault_d = 1'b1;
                    state_d = IFC_HALT;
                end else if (redir_ok) begin
                    pc_d = redirect_pc;
                end
            end
            IFC_HALT: begin
                state_d = IFC_HALT;
            end
            default: state_d = IFC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IFC_IDLE;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_pc_q     <= RESET_PC;
            if_instr_q  <= 32'd0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'd0;
            fault_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            fault_q     <= fault_d;
            halt_pend_q <= halt_pend_d;
        end
    end

`ifdef IFC_BOOT_LOADER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_we_q    <= 1'b0;
            imem_wdata_q <= 32'd0;
            load_ack_q   <= 1'b0;
        end else begin
            imem_we_q    <= imem_we_d;
            imem_wdata_q <= imem_wdata_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_wdata = imem_wdata_q;
    assign load_ack   = load_ack_q;
`else
    logic unused_load;
    assign unused_load = ^{load_req, load_addr, load_data};

    assign imem_we    = 1'b0;
    assign imem_wdata = 32'd0;
    assign load_ack   = 1'b0;
`endif

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign fault     = fault_q;

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: imem_req  output  1  one-cycle read request to instruction memory.
REQ-005 Port: imem_addr  output  32  byte address, which is PC for reads and load_addr for writes.
REQ-006 Port: imem_rvalid  input  1  read data valid; exactly one per accepted request, at least 1 cycle later.
REQ-007 Port: imem_rdata  input  32  instruction word.
REQ-008 Port: imem_we  output  1  one-cycle write strobe.
REQ-009 Port: imem_wdata  output  32  write data.
REQ-010 Port: if_valid  output  1  instruction presented to decode.
REQ-011 Port: if_ready  input  1  decode accepts.
REQ-012 Port: if_pc  output  32  PC of presented instruction.
REQ-013 Port: if_instr  output  32  presented instruction.
REQ-014 Port: redirect_valid  input  1  branch/jump taken.
REQ-015 Port: redirect_pc  input  32  target address.
REQ-016 Port: load_req  input  1  program-load write request.
REQ-017 Port: load_addr  input  32  load byte address.
REQ-018 Port: load_data  input  32  load word.
REQ-019 Port: load_ack  output  1  one-cycle pulse when the write is issued.
REQ-020 Port: fault  output  1  sticky misaligned-redirect flag.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, HOLD, DROP, LOAD, HALT; one outstanding read maximum.
REQ-022 IDLE: priority redirect > load_req > fetch; fetch drives imem_req=1, imem_addr=pc → FETCH next cycle.
REQ-023 FETCH: on imem_rvalid latch if_instr=rdata, if_pc=pc, pc=pc+4 (mod 2^32, FFFF_FFFC→0), if_valid=1 next cycle → HOLD.
REQ-024 HOLD: if_instr/if_pc stable while if_valid && !if_ready; on handshake, if_valid=0 next cycle → IDLE.
REQ-025 Redirect with redirect_pc[1:0]==0, any non-HALT state: pc=redirect_pc, if_valid=0 next cycle, imem_req suppressed that cycle; from FETCH → DROP, else → IDLE.
REQ-026 DROP: next imem_rvalid discarded, no output change → IDLE; a further redirect in DROP updates pc only.
REQ-027 Redirect with redirect_pc[1:0]!=0: fault=1, if_valid=0, → HALT after any outstanding read returns; HALT exits only by reset.
REQ-028 LOAD (entered from IDLE): one cycle imem_we=1, imem_addr=load_addr, imem_wdata=load_data, load_ack=1 → IDLE; pc unchanged.
REQ-029 imem_rvalid outside FETCH/DROP SHALL be ignored; imem_req and imem_we never asserted in the same cycle.

Reset
REQ-030 reset_n low SHALL asynchronously set state=IDLE, pc=RESET_PC, if_pc=RESET_PC, and all other outputs and if_instr to 0, including fault.
REQ-031 Reset mid-FETCH abandons the outstanding read; instruction memory shares reset_n, so no stale rvalid follows.
REQ-032 First imem_req SHALL occur in the first clk edge cycle after reset_n deasserts.

Configuration
REQ-033 Macro IFC_BOOT_LOADER_EN defined: LOAD state and load path are present as specified.
REQ-034 Macro IFC_BOOT_LOADER_EN undefined: LOAD state is absent, load_* inputs are ignored, and load_ack, imem_we and imem_wdata are tied to 0; ports are retained.

Structure
REQ-035 Shared package/header SHALL hold the FSM state encodings and the IFC_PC_STEP=4 constant.
REQ-036 No sub-module is required.

Verification
REQ-037 Reset, 2-cycle memory latency, if_ready=1 → imem_addr sequence 0,4,8; if_pc 0,4,8 matching rdata.
REQ-038 if_ready=0 for 5 cycles in HOLD → if_instr/if_pc stable, no imem_req; release → next request at pc+4.
REQ-039 Redirect to 0x40 while in FETCH → the returning word is dropped; next imem_addr=0x40; if_pc=0x40.
REQ-040 Redirect to 0x42 → fault=1, if_valid=0, no further imem_req until reset_n pulse; afterwards fault=0 and addr=RESET_PC.
REQ-041 load_req, addr 0x10, data 0xDEADBEEF, issued in IDLE → one-cycle imem_we with those values plus load_ack; pc unchanged; macro off → no imem_we.
REQ-042 redirect_valid and load_req in the same IDLE cycle → redirect taken, no write; load issued on a later IDLE cycle.
